// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the pointer-width rule.
// Conversions work on zero-extended pointers up to MAX_PTR_W bits; callers truncate to PTR_W.
package fifo_pkg;
    localparam int MAX_PTR_W = 32;
    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Pointers carry one extra bit over the address to tell full from empty after wrap.
    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready output register for the FIFO read port.
module fifo_out_reg #(
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pop,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                dout_ready,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout       <= rdata;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fifo_rd_port.sv
// Async FIFO read-side controller (rclk domain): read pointer, empty flag, output stage.
// Define FIFO_RD_AEMPTY_EN to build the registered almost-empty flag.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);
    localparam int PTR_W = ptr_width(ADDRSIZE);

    logic [PTR_W-1:0] rbin, rbinnext, rgraynext;
    logic             pop;

    assign pop       = !rempty && (!dout_valid || dout_ready);
    assign rbinnext  = rbin + PTR_W'(pop);
    assign rgraynext = PTR_W'(bin2gray(MAX_PTR_W'(rbinnext)));
    assign raddr     = rbin[ADDRSIZE-1:0];

    // Full-width compare: the MSB separates "empty" from "full after wrap".
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
        end
    end

`ifdef FIFO_RD_AEMPTY_EN
    logic [PTR_W-1:0] wbin, level;
    assign wbin  = PTR_W'(gray2bin(MAX_PTR_W'(rq2_wptr)));
    assign level = wbin - rbinnext;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) raempty <= 1'b1;
        else      raempty <= (level <= PTR_W'(AEMPTY_THRESH));
    end
`else
    assign raempty = 1'b0;
`endif

    fifo_out_reg #(.DATASIZE(DATASIZE)) u_out (
        .clk        (rclk),
        .rst        (rrst),
        .pop        (pop),
        .rdata      (rdata),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid)
    );
endmodule

// File: tb/tb_fifo_rd_port.sv
// Bench for fifo_rd_port: vector table for reset/single word, scoreboard for streams.
module tb_fifo_rd_port;
    localparam int DW = 8;
    localparam int AW = 4;
`ifdef FIFO_RD_AEMPTY_EN
    localparam bit AE_EN = 1'b1;
`else
    localparam bit AE_EN = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic [AW:0]   rq2_wptr = '0;
    logic [DW-1:0] rdata;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty, raempty, dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout;
    logic [DW-1:0] mem [16];

    always #5 rclk = ~rclk;
    assign rdata = mem[raddr];

    fifo_rd_port #(.DATASIZE(DW), .ADDRSIZE(AW), .AEMPTY_THRESH(2)) dut (
        .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata(rdata), .raddr(raddr),
        .rptr(rptr), .rempty(rempty), .raempty(raempty), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    int            n_chk = 0, n_pass = 0;
    int            acc_cnt = 0, wcnt = 0;
    logic [DW-1:0] sb [$];

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ {1'b0, b[AW:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_word(input logic [DW-1:0] v);
        mem[4'(wcnt)] = v;
        sb.push_back(v);
        wcnt++;
        rq2_wptr = gray(5'(wcnt));
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge rclk); #1;
            if (dout_valid) return;
        end
        check("wait_valid_timeout", 32'(dout_valid), 32'd1);
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        rq2_wptr = '0;
        wcnt = 0;
        acc_cnt = 0;
        sb.delete();
        @(posedge rclk); #1;
        rrst = 1'b0;
    endtask

    // Scoreboard: a word leaves at the next edge whenever valid && ready here.
    always @(negedge rclk) begin
        if (!rrst && dout_valid && dout_ready) begin
            acc_cnt++;
            if (sb.size() == 0) check("sb_nonempty", 32'(sb.size()), 32'd1);
            else check("sb_data", 32'(dout), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic [4:0]  wptr;
        logic        ready;
        logic        e_empty;
        logic        e_valid;
        logic [4:0]  e_rptr;
        logic [3:0]  e_raddr;
        logic        chk_dout;
        logic [7:0]  e_dout;
    } vec_t;
    vec_t tv [6];

    initial begin
        logic [AW-1:0] prev_raddr;
        logic [AW:0]   prev_rptr;
        int gaps, empty_early, n0, rb;
        bit seen_first, raddr_wrap, rptr_wrap;

        //         rst  wptr      rdy emp val rptr      raddr chk dout
        tv[0] = '{1'b1, 5'b00011, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b1, 8'h00};
        tv[1] = '{1'b1, 5'b00011, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b1, 8'h00};
        tv[2] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 8'h00};
        tv[3] = '{1'b0, 5'b00001, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 8'h00};
        tv[4] = '{1'b0, 5'b00001, 1'b1, 1'b1, 1'b1, 5'd1, 4'd1, 1'b1, 8'hA5};
        tv[5] = '{1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, 5'd1, 4'd1, 1'b0, 8'h00};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 8'hA5;
        sb.push_back(8'hA5);

        // Reset hold and single-word latency
        for (int i = 0; i < 6; i++) begin
            rrst = tv[i].rst; rq2_wptr = tv[i].wptr; dout_ready = tv[i].ready;
            @(posedge rclk); #1;
            check($sformatf("v%0d_rempty", i), 32'(rempty), 32'(tv[i].e_empty));
            check($sformatf("v%0d_valid", i), 32'(dout_valid), 32'(tv[i].e_valid));
            check($sformatf("v%0d_rptr", i), 32'(rptr), 32'(tv[i].e_rptr));
            check($sformatf("v%0d_raddr", i), 32'(raddr), 32'(tv[i].e_raddr));
            check($sformatf("v%0d_raempty", i), 32'(raempty), 32'(AE_EN));
            if (tv[i].chk_dout) check($sformatf("v%0d_dout", i), 32'(dout), 32'(tv[i].e_dout));
        end

        // Back-pressure: 11 held with raddr parked at 1, then 11,22,33 back to back
        do_reset();
        dout_ready = 1'b0;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(posedge rclk); #1;
            check("bp_dout", 32'(dout), 32'h11);
            check("bp_valid", 32'(dout_valid), 32'd1);
            check("bp_raddr", 32'(raddr), 32'd1);
        end
        dout_ready = 1'b1;
        @(posedge rclk); #1;
        check("bp_dout2", 32'(dout), 32'h22);
        check("bp_valid2", 32'(dout_valid), 32'd1);
        @(posedge rclk); #1;
        check("bp_dout3", 32'(dout), 32'h33);
        check("bp_valid3", 32'(dout_valid), 32'd1);
        @(posedge rclk); #1;
        check("bp_drained_valid", 32'(dout_valid), 32'd0);
        check("bp_drained_empty", 32'(rempty), 32'd1);

        // Wrap: 40 words streamed one per cycle through pointer and address wrap
        n0 = acc_cnt; gaps = 0; empty_early = 0;
        seen_first = 0; raddr_wrap = 0; rptr_wrap = 0;
        prev_raddr = raddr; prev_rptr = rptr;
        for (int i = 0; i < 40; i++) begin
            push_word(8'(i * 7 + 3));
            @(posedge rclk); #1;
            if (dout_valid) seen_first = 1;
            else if (seen_first) gaps++;
            if (seen_first && rempty) empty_early++;
            if (prev_raddr == 4'd15 && raddr == 4'd0) raddr_wrap = 1;
            if (prev_rptr == 5'b10000 && rptr == 5'b00000) rptr_wrap = 1;
            prev_raddr = raddr; prev_rptr = rptr;
        end
        for (int i = 0; i < 10 && dout_valid; i++) begin
            @(posedge rclk); #1;
        end
        check("wrap_gaps", 32'(gaps), 32'd0);
        check("wrap_early_empty", 32'(empty_early), 32'd0);
        check("wrap_count", 32'(acc_cnt - n0), 32'd40);
        check("wrap_sb_left", 32'(sb.size()), 32'd0);
        check("wrap_raddr", 32'(raddr_wrap), 32'd1);
        check("wrap_rptr", 32'(rptr_wrap), 32'd1);
        check("wrap_final_empty", 32'(rempty), 32'd1);
        check("wrap_final_valid", 32'(dout_valid), 32'd0);

        // Reset mid-stream clears everything in the same cycle
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
        wait_valid(20);
        #2 rrst = 1'b1;
        #1;
        check("mrst_valid", 32'(dout_valid), 32'd0);
        check("mrst_empty", 32'(rempty), 32'd1);
        check("mrst_rptr", 32'(rptr), 32'd0);
        check("mrst_raddr", 32'(raddr), 32'd0);
        check("mrst_dout", 32'(dout), 32'd0);
        check("mrst_raempty", 32'(raempty), 32'(AE_EN));
        rq2_wptr = '0; wcnt = 0; acc_cnt = 0; sb.delete();
        @(posedge rclk); #1;
        rrst = 1'b0;
        @(posedge rclk); #1;
        check("post_rst_empty", 32'(rempty), 32'd1);
        check("post_rst_valid", 32'(dout_valid), 32'd0);

        // Almost-empty across levels 4..0 while draining one word per cycle
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'h50 + i));
        for (int i = 0; i < 6; i++) begin
            @(posedge rclk); #1;
            rb = acc_cnt + int'(dout_valid);
            check($sformatf("ae_lvl%0d", wcnt - rb), 32'(raempty),
                  32'(AE_EN ? (wcnt - rb <= 2) : 1'b0));
        end
        check("ae_sb_left", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
